// File: rtl/gpio_in_pkg.sv
// Shared constants for the GPIO input-conditioning block.
// Holds the word-offset register map, the read value returned for unmapped
// offsets, and the debounce counter width derivation.
package gpio_in_pkg;

    // Word-address width of HADDR[23:2]
    localparam int unsigned ADDR_W = 22;

    localparam logic [ADDR_W-1:0] DIN_OFF       = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] IE_OFF        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RISE_EN_OFF   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] FALL_EN_OFF   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] STATUS_OFF    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] DB_PRESC_OFF  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] DB_BYPASS_OFF = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] LEVEL_OFF     = ADDR_W'(7);

    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    localparam int unsigned PRESC_W = 16;

    // Counter must hold 0..DB_COUNT, so it never wraps
    function automatic int unsigned db_cnt_width(input int unsigned db_count);
        return $clog2(db_count + 1);
    endfunction

    localparam int unsigned DB_COUNT_DEF = 4;
    localparam int unsigned DB_CNT_W     = db_cnt_width(DB_COUNT_DEF);

endpackage

// File: rtl/gpio_in_debounce.sv
// One-pin conditioner: pad synchroniser, debounce tick counter and stable flop.
// Ports:
//   HCLK, HRESETn  clock and async active-low reset
//   i_pad          raw asynchronous pad input
//   i_tick         shared debounce prescaler tick
//   i_bypass       1: skip filtering, follow the synchronised pad each cycle
//   o_din          conditioned (registered) level
//   o_din_next_c   value o_din takes on the next edge, for edge detection
module gpio_in_debounce
    import gpio_in_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_COUNT    = 4
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic i_pad,
    input  logic i_tick,
    input  logic i_bypass,
    output logic o_din,
    output logic o_din_next_c
);

    localparam int unsigned CNT_W = db_cnt_width(DB_COUNT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_din;
    logic                   w_sync;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_din_next;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Accept a new level only after DB_COUNT consecutive disagreeing ticks
    always_comb begin
        w_cnt_next = r_cnt;
        w_din_next = r_din;
        if (i_bypass) begin
            w_cnt_next = '0;
            w_din_next = w_sync;
        end else if (w_sync == r_din) begin
            w_cnt_next = '0;
        end else if (i_tick) begin
            if (r_cnt == CNT_W'(DB_COUNT - 1)) begin
                w_din_next = w_sync;
                w_cnt_next = '0;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_din  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
            r_cnt  <= w_cnt_next;
            r_din  <= w_din_next;
        end
    end

    assign o_din        = r_din;
    assign o_din_next_c = w_din_next;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning with an AHB-lite configuration slave.
// Synchronises and debounces each pad, drives the GPIO block's WGPIODIN via DIN,
// latches enabled edges into STATUS (W1C) and raises IRQ = |(STATUS & IE).
// Optional build macro GPIO_IN_LEVEL_IRQ_EN adds a LEVEL register at offset 0x7:
// level pins make STATUS track DIN instead of latching edges.
// Ports:
//   HCLK, HRESETn           clock, async active-low reset
//   HSEL..HWDATA            AHB-lite slave inputs (HSIZE registered, unused)
//   HRDATA, HREADYOUT, HRESP AHB-lite slave outputs (zero wait, OKAY)
//   PAD_IN                  raw pad inputs
//   DIN                     conditioned inputs
//   IRQ                     combined interrupt
module gpio_in_cond
    import gpio_in_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_COUNT    = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [23:2]      HADDR,
    input  logic             HREADY,
    input  logic             HWRITE,
    input  logic [1:0]       HTRANS,
    input  logic [2:0]       HSIZE,
    input  logic [31:0]      HWDATA,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic [1:0]       HRESP,
    input  logic [WIDTH-1:0] PAD_IN,
    output logic [WIDTH-1:0] DIN,
    output logic             IRQ
);

    logic              r_sel;
    logic              r_write;
    logic              r_trans;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic              w_wr_en;

    logic [WIDTH-1:0]   r_ie;
    logic [WIDTH-1:0]   r_rise_en;
    logic [WIDTH-1:0]   r_fall_en;
    logic [WIDTH-1:0]   r_status;
    logic [WIDTH-1:0]   r_db_bypass;
    logic [PRESC_W-1:0] r_db_presc;
    logic [PRESC_W-1:0] r_presc_cnt;
`ifdef GPIO_IN_LEVEL_IRQ_EN
    logic [WIDTH-1:0]   r_level;
`endif

    logic             w_tick;
    logic [WIDTH-1:0] w_din;
    logic [WIDTH-1:0] w_din_next;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_status_next;
    logic             w_unused;

    // Address phase capture
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sel   <= 1'b0;
            r_write <= 1'b0;
            r_trans <= 1'b0;
            r_addr  <= '0;
            r_size  <= '0;
        end else begin
            r_sel   <= HSEL & HREADY;
            r_write <= HWRITE;
            r_trans <= HTRANS[1];
            r_addr  <= HADDR;
            r_size  <= HSIZE;
        end
    end

    assign w_wr_en   = r_sel & r_write & r_trans;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 2'b00;
    assign w_unused  = ^{r_size, HTRANS[0], HWDATA};

    // Shared debounce tick, one every DB_PRESC+1 cycles
    assign w_tick = (r_presc_cnt == '0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_presc_cnt <= '0;
        end else if (w_wr_en && (r_addr == DB_PRESC_OFF)) begin
            r_presc_cnt <= HWDATA[PRESC_W-1:0];
        end else if (w_tick) begin
            r_presc_cnt <= r_db_presc;
        end else begin
            r_presc_cnt <= r_presc_cnt - PRESC_W'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_in_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_COUNT    (DB_COUNT)
        ) u_db (
            .HCLK         (HCLK),
            .HRESETn      (HRESETn),
            .i_pad        (PAD_IN[i]),
            .i_tick       (w_tick),
            .i_bypass     (r_db_bypass[i]),
            .o_din        (w_din[i]),
            .o_din_next_c (w_din_next[i])
        );
    end

    assign DIN = w_din;

    // Edge latch: a set on the same cycle as a W1C clear wins
    always_comb begin
        w_set = (~w_din & w_din_next & r_rise_en) | (w_din & ~w_din_next & r_fall_en);
        w_clr = (w_wr_en && (r_addr == STATUS_OFF)) ? HWDATA[WIDTH-1:0] : '0;
        w_status_next = (r_status & ~w_clr) | w_set;
`ifdef GPIO_IN_LEVEL_IRQ_EN
        // Level pins mirror the conditioned input in step with DIN
        w_status_next = (w_status_next & ~r_level) | (w_din_next & r_level);
`endif
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ie        <= '0;
            r_rise_en   <= '0;
            r_fall_en   <= '0;
            r_status    <= '0;
            r_db_bypass <= '0;
            r_db_presc  <= '0;
`ifdef GPIO_IN_LEVEL_IRQ_EN
            r_level     <= '0;
`endif
        end else begin
            r_status <= w_status_next;
            if (w_wr_en) begin
                case (r_addr)
                    IE_OFF:        r_ie        <= HWDATA[WIDTH-1:0];
                    RISE_EN_OFF:   r_rise_en   <= HWDATA[WIDTH-1:0];
                    FALL_EN_OFF:   r_fall_en   <= HWDATA[WIDTH-1:0];
                    DB_PRESC_OFF:  r_db_presc  <= HWDATA[PRESC_W-1:0];
                    DB_BYPASS_OFF: r_db_bypass <= HWDATA[WIDTH-1:0];
`ifdef GPIO_IN_LEVEL_IRQ_EN
                    LEVEL_OFF:     r_level     <= HWDATA[WIDTH-1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    // Data-phase read mux
    always_comb begin
        HRDATA = UNMAPPED_RDATA;
        case (r_addr)
            DIN_OFF:       HRDATA = 32'(w_din);
            IE_OFF:        HRDATA = 32'(r_ie);
            RISE_EN_OFF:   HRDATA = 32'(r_rise_en);
            FALL_EN_OFF:   HRDATA = 32'(r_fall_en);
            STATUS_OFF:    HRDATA = 32'(r_status);
            DB_PRESC_OFF:  HRDATA = 32'(r_db_presc);
            DB_BYPASS_OFF: HRDATA = 32'(r_db_bypass);
`ifdef GPIO_IN_LEVEL_IRQ_EN
            LEVEL_OFF:     HRDATA = 32'(r_level);
`endif
            default: ;
        endcase
    end

    assign IRQ = |(r_status & r_ie);

endmodule

// File: doc/gpio_in_cond.md
Name: gpio_in_cond

Overview:
Input-conditioning stage that sits directly upstream of the AHB-lite GPIO register block and drives its 16-bit WGPIODIN input. Per pin it synchronises the raw pad input, applies an optional debounce filter, detects edges and raises a maskable interrupt. It has its own small AHB-lite slave for configuration and interrupt status.

Parameters:
WIDTH, 16, number of GPIO pins
SYNC_STAGES, 2, synchroniser flop depth (min 2)
DB_COUNT, 4, consecutive debounce ticks required to accept a new level (min 1)

Ports:
HCLK  input  1  clock
HRESETn  input  1  reset, asynchronous, active-low
HSEL  input  1  slave select
HADDR  input  [23:2]  word address
HREADY  input  1  bus ready
HWRITE  input  1  write control
HTRANS  input  2  transfer type
HSIZE  input  3  transfer size (registered, unused)
HWDATA  input  32  write data
HRDATA  output  32  read data
HREADYOUT  output  1  tied 1
HRESP  output  2  tied 0
PAD_IN  input  WIDTH  raw asynchronous pad inputs
DIN  output  WIDTH  conditioned inputs; connects to the GPIO block's WGPIODIN
IRQ  output  1  OR of (STATUS & IE)

Behaviour:
- Bus: address-phase signals are registered on every HCLK edge, as in the other AHB_sys_0 slaves. wr_en = IOSEL & IOWRITE & IOTRANS. Zero wait states; HRESP = 0.
- Register map (word offset; every field WIDTH bits, upper bits read 0):
  - 0x0 DIN (RO)
  - 0x1 IE
  - 0x2 RISE_EN
  - 0x3 FALL_EN
  - 0x4 STATUS (W1C)
  - 0x5 DB_PRESC (16 bits)
  - 0x6 DB_BYPASS
  - Unmapped reads return 0xDEADBEEF. Writes to DIN or unmapped offsets are ignored.
- Reset: all registers, synchroniser flops, prescaler, debounce counters and DIN are 0; IRQ = 0.
- Synchroniser: PAD_IN passes through SYNC_STAGES flops to give sync[i].
- Prescaler: a down-counter reloads from DB_PRESC and emits a 1-cycle tick on reaching 0, so there is one tick every DB_PRESC+1 cycles. DB_PRESC = 0 gives a tick every cycle. A write to DB_PRESC reloads the counter on the write-data cycle.
- Debounce, per pin, when DB_BYPASS[i] = 0:
  - If sync == DIN: the counter clears, regardless of tick.
  - If sync != DIN on a tick: the counter increments. When it would reach DB_COUNT, DIN[i] <= sync[i] and the counter clears.
  - A glitch shorter than DB_COUNT ticks never changes DIN.
  - Counter width is clog2(DB_COUNT+1); no wrap is possible.
- Bypass: when DB_BYPASS[i] = 1, DIN[i] <= sync[i] every cycle and the counter is held at 0.
- Latency: pad change to DIN is SYNC_STAGES+1 cycles in bypass, and SYNC_STAGES+DB_COUNT cycles when debounced with DB_PRESC = 0.
- Edge detect: rise = ~DIN & DIN_next; fall = DIN & ~DIN_next. STATUS[i] is set on the same edge that DIN changes if (rise & RISE_EN) | (fall & FALL_EN).
- STATUS write: a 1 clears the bit; a 0 has no effect. If a set and a clear hit the same bit in the same cycle, the set wins.
- IRQ is combinational: |(STATUS & IE). Clearing IE masks IRQ but leaves STATUS unchanged.
- After reset a pad held high produces a rising edge on DIN. STATUS stays 0 because RISE_EN resets to 0.

Optional Feature:
GPIO_IN_LEVEL_IRQ_EN
- With it: adds a LEVEL register at 0x7. When LEVEL[i] = 1:
  - STATUS[i] is forced to DIN[i] every cycle; W1C has no effect while DIN[i] = 1.
  - RISE_EN[i] and FALL_EN[i] are ignored.
- Without it: offset 0x7 is unmapped (reads 0xDEADBEEF); edge mode only.

Decomposition:
- Shared package gpio_in_pkg holds:
  - register offset constants (DIN_OFF .. LEVEL_OFF)
  - the unmapped read value 0xDEADBEEF
  - localparam DB_CNT_W derivation.
- Sub-module: gpio_in_debounce (one pin: synchroniser, counter, stable flop), instantiated WIDTH times with the tick shared.

Test Plan:
1. Reset with PAD_IN = 0xFFFF -> DIN = 0x0000, IRQ = 0; DIN reaches 0xFFFF after 2+4 cycles (DB_PRESC = 0); STATUS stays 0.
2. DB_BYPASS = 0xFFFF, RISE_EN = 0x0001, IE = 0x0001; PAD_IN[0] 0->1 -> DIN[0] = 1 after 3 cycles, STATUS = 0x0001 and IRQ = 1 on the same edge; write STATUS = 0x0001 -> IRQ = 0 next cycle.
3. DB_PRESC = 0, DB_COUNT = 4; 3-cycle high glitch on PAD_IN[5] -> DIN unchanged; 4-cycle pulse -> DIN[5] = 1 exactly 6 cycles after the pad edge.
4. DB_PRESC = 9; PAD_IN[2] held high -> DIN[2] changes within 31–40 cycles (+2 sync); reading 0x5 returns 0x00000009.
5. FALL_EN[3] = 1, falling edge on pin 3 coincident with a W1C write of STATUS[3] -> STATUS[3] = 1 (set wins); a read of offset 0x8 returns 0xDEADBEEF.
6. With GPIO_IN_LEVEL_IRQ_EN: LEVEL[4] = 1, IE[4] = 1, pin 4 high -> IRQ = 1 and a W1C does not clear it; pin 4 low -> STATUS[4] = 0, IRQ = 0.
